pll_lock_supervisor: RTL and testbench

//  Sits between the board reset and the core PLL. Runs on the free-running PLL reference clock.

---
 rtl/pll_lock_supervisor_pkg.sv | 29 ++
 rtl/pll_lock_supervisor_if.sv | 13 +
 rtl/pll_lock_supervisor_sync.sv | 18 +
 rtl/pll_lock_supervisor.sv | 118 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_REL,
    S_RUN
  } state_t;

  localparam logic [7:0] RELOCK_MAX = 8'd255;

  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  localparam int CNT_W = cnt_width(16, 742500, 1024, 64);

  function automatic logic [7:0] sat_inc(logic [7:0] v);
    return (v == RELOCK_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and domain-side signals of the lock supervisor; master = supervisor.
interface pll_lock_supervisor_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   all_ready;
  logic [7:0]             relock_cnt;

  modport master (input pll_locked, output pll_rst, dom_rst, all_ready, relock_cnt);
  modport slave  (output pll_locked, input pll_rst, dom_rst, all_ready, relock_cnt);
endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// N-flop single-bit synchronizer with synchronous clear to 0.
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, releases domain resets in order.
// Build option PLL_SUP_TIMEOUT_EN adds the lock-wait timeout with automatic PLL restart.
//
// state    | meaning
// S_PLLRST | PLL held in reset for RST_PULSE_CYCLES
// S_WAIT   | PLL reset released, waiting for synchronized lock
// S_STABLE | lock seen, qualifying for STABLE_CYCLES consecutive cycles
// S_REL    | releasing dom_rst bits one per RELEASE_GAP_CYCLES
// S_RUN    | every domain released, all_ready high
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 742500,
  parameter int STABLE_CYCLES       = 1024,
  parameter int RELEASE_GAP_CYCLES  = 64
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_supervisor_if.master bus
);
  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                STABLE_CYCLES, RELEASE_GAP_CYCLES);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   lk_s;
  logic                   pll_rst_q;
  logic                   all_ready_q;
  logic [NUM_DOMAINS-1:0] dom_rst_q;
  logic [NUM_DOMAINS-1:0] dom_next;
  logic [7:0]             relock_q;

  pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lk_s)
  );

  // Releases walk upward from bit 0, so a left shift clears the next bit.
  assign dom_next = dom_rst_q << 1;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      pll_rst_q   <= 1'b1;
      dom_rst_q   <= '1;
      all_ready_q <= 1'b0;
      relock_q    <= 8'd0;
    end else if (!lk_s && (state == S_REL || state == S_RUN)) begin
      // Loss of lock outranks any gap terminal count in the same cycle.
      state       <= S_PLLRST;
      cnt         <= '0;
      pll_rst_q   <= 1'b1;
      dom_rst_q   <= '1;
      all_ready_q <= 1'b0;
      relock_q    <= sat_inc(relock_q);
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        S_PLLRST: begin
          if (cnt == CW'(RST_PULSE_CYCLES - 1)) begin
            state     <= S_WAIT;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (lk_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end
`ifdef PLL_SUP_TIMEOUT_EN
          else if (cnt == CW'(LOCK_TIMEOUT_CYCLES)) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            relock_q  <= sat_inc(relock_q);
          end
`endif
        end
        S_STABLE: begin
          if (!lk_s) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 2)) begin
            // The WAIT cycle that first saw lock is the first stable cycle.
            state       <= (NUM_DOMAINS == 1) ? S_RUN : S_REL;
            cnt         <= '0;
            dom_rst_q   <= dom_next;
            all_ready_q <= (NUM_DOMAINS == 1);
          end
        end
        S_REL: begin
          if (cnt == CW'(RELEASE_GAP_CYCLES - 1)) begin
            cnt       <= '0;
            dom_rst_q <= dom_next;
            if (dom_next == '0) begin
              state       <= S_RUN;
              all_ready_q <= 1'b1;
            end
          end
        end
        S_RUN: ;
        default: state <= S_PLLRST;
      endcase
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.dom_rst    = dom_rst_q;
  assign bus.all_ready  = all_ready_q;
  assign bus.relock_cnt = relock_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase-level model turns each lock waveform into
// the list of output changes; a negedge monitor pops and compares every change the DUT shows.
module tb_pll_lock_supervisor;
  localparam int ND   = 4;
  localparam int RSTP = 4;
  localparam int TMO  = 100;
  localparam int STB  = 8;
  localparam int GAP  = 3;
  localparam int TW   = ND + 10;
  localparam logic [TW-1:0] RST_T = {1'b1, {ND{1'b1}}, 1'b0, 8'd0};

  typedef struct {
    int            cyc;
    logic [TW-1:0] val;
  } exp_t;

  logic refclk;
  logic rst;
  logic pll_locked;
  int   checks;
  int   errors;
  int   cyc;
  bit   mon_en;
  bit   chk_rst;
  bit   last;
  bit   lock_a[];
  exp_t exp_q[$];
  exp_t got_e;
  logic [TW-1:0] cur;
  logic [TW-1:0] prev;

  pll_lock_supervisor_if #(.NUM_DOMAINS(ND)) bus ();
  assign bus.pll_locked = pll_locked;

  pll_lock_supervisor #(
    .NUM_DOMAINS         (ND),
    .SYNC_STAGES         (2),
    .RST_PULSE_CYCLES    (RSTP),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .STABLE_CYCLES       (STB),
    .RELEASE_GAP_CYCLES  (GAP)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Synchronized lock as seen by the controller at posedge t (two-flop latency, cleared by rst).
  function automatic bit l_at(int t);
    return (t >= 2) ? lock_a[t-2] : 1'b0;
  endfunction

  function automatic int find_l(int from, int to, bit v, int h);
    for (int t = from; t <= to && t < h; t++)
      if (l_at(t) == v) return t;
    return -1;
  endfunction

  task automatic push(int c, bit prst, logic [ND-1:0] dom, bit rdy, int rel);
    exp_t x;
    x.cyc = c;
    x.val = {prst, dom, rdy, 8'(rel)};
    exp_q.push_back(x);
  endtask

  // Phase model: pulse -> wait for lock -> 8-cycle run of lock -> timed releases -> run until a drop.
  task automatic build_model(int h);
    int e, ws, q, z, r, t, relock;
    bit done;
    logic [ND-1:0] all1;
    all1 = '1;
    relock = 0;
    e = -1;
    done = 0;
    while (!done) begin
      ws = e + RSTP;
      if (ws >= h) break;
      push(ws, 1'b0, all1, 1'b0, relock);
      r = -1;
      while (r < 0 && !done) begin
`ifdef PLL_SUP_TIMEOUT_EN
        q = find_l(ws + 1, ws + 1 + TMO, 1'b1, h);
        if (q < 0) begin
          t = ws + 1 + TMO;
          if (t >= h) done = 1;
          else begin
            if (relock < 255) relock++;
            e = t;
            push(e, 1'b1, all1, 1'b0, relock);
          end
          break;
        end
`else
        q = find_l(ws + 1, h - 1, 1'b1, h);
        if (q < 0) begin
          done = 1;
          break;
        end
`endif
        z = find_l(q + 1, q + STB - 1, 1'b0, h);
        if (z >= 0) ws = z;
        else if (q + STB - 1 >= h) done = 1;
        else r = q + STB - 1;
      end
      if (done) break;
      if (r < 0) continue;
      z = find_l(r + 1, h - 1, 1'b0, h);
      for (int i = 0; i < ND; i++) begin
        t = r + i * GAP;
        if ((z >= 0 && t >= z) || t >= h) break;
        push(t, 1'b0, all1 << (i + 1), (i == ND - 1), relock);
      end
      if (z < 0) break;
      if (relock < 255) relock++;
      e = z;
      push(e, 1'b1, all1, 1'b0, relock);
    end
  endtask

  task automatic gen_step(int h, int rise);
    lock_a = new[h];
    for (int c = 0; c < h; c++) lock_a[c] = (c >= rise);
  endtask

  task automatic gen_random(int h);
    int c, len;
    bit v;
    lock_a = new[h];
    c = 0;
    v = 1'b0;
    while (c < h) begin
      if (v) len = $urandom_range(60, 1);
      else if ($urandom_range(3, 0) == 0) len = $urandom_range(40, 1);
      else len = $urandom_range(3, 1);
      for (int k = 0; k < len && c < h; k++) begin
        lock_a[c] = v;
        c++;
      end
      v = !v;
    end
  endtask

  task automatic run_episode(int h, int rc);
    rst = 1'b1;
    repeat (rc) @(posedge refclk);
    chk_rst = 1'b1;
    @(negedge refclk); #1;
    chk_rst = 1'b0;
    rst = 1'b0;
    build_model(h);
    for (int c = 0; c < h; c++) begin
      pll_locked = lock_a[c];
      @(posedge refclk);
      cyc = c;
      mon_en = 1'b1;
      last = (c == h - 1);
      @(negedge refclk); #1;
    end
    mon_en = 1'b0;
    last = 1'b0;
  endtask

  always @(negedge refclk) begin
    cur = {bus.pll_rst, bus.dom_rst, bus.all_ready, bus.relock_cnt};
    if (chk_rst) begin
      checks++;
      if (cur !== RST_T) begin
        errors++;
        $display("FAIL reset_values got=%h expected=%h", cur, RST_T);
      end
      prev = RST_T;
    end else if (mon_en) begin
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h expected=no_change", cyc, cur);
        end else begin
          got_e = exp_q.pop_front();
          if (got_e.cyc != cyc || got_e.val !== cur) begin
            errors++;
            $display("FAIL out_event cyc=%0d got=%h expected=%h at cyc=%0d",
                     cyc, cur, got_e.val, got_e.cyc);
          end
        end
        prev = cur;
      end
      if (last) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_events got=%0d pending expected=0 (next at cyc=%0d val=%h)",
                   exp_q.size(), exp_q[0].cyc, exp_q[0].val);
        end
        exp_q.delete();
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    mon_en = 1'b0;
    chk_rst = 1'b0;
    last = 1'b0;
    cyc = 0;
    prev = RST_T;

    gen_step(60, 10);
    run_episode(60, 2);

    gen_step(60, 10);
    lock_a[16] = 1'b0;
    run_episode(60, 1);

    gen_step(100, 10);
    for (int c = 50; c <= 52; c++) lock_a[c] = 1'b0;
    run_episode(100, 1);

    gen_step(80, 10);
    lock_a[23] = 1'b0;
    run_episode(80, 1);

    gen_step(180, 10);
    lock_a[40] = 1'b0;
    lock_a[80] = 1'b0;
    lock_a[120] = 1'b0;
    run_episode(180, 1);

    gen_step(27200, 27200);
    run_episode(27200, 1);

    lock_a = new[5600];
    for (int c = 0; c < 5600; c++) lock_a[c] = ((c % 20) != 19);
    run_episode(5600, 1);

    for (int n = 0; n < 6; n++) begin
      gen_random(500);
      run_episode(500, 1);
    end

    rst = 1'b1;
    @(posedge refclk);
    chk_rst = 1'b1;
    @(negedge refclk); #1;
    chk_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
